afe_spi_master: RTL
===================

// Module: afe_spi_master
// PURPOSE
// - FPGA-side SPI master for the AFE CPLD's SPI slave port; one transaction = exactly 8 SCLK pulses
//   with CS_B low, carrying one GPIO byte out (MOSI) and one ToT byte in (MISO), both MSB first.
// - Slave behaviour it must match: it shifts MOSI in and advances its MISO bit pointer on SCLK rising
//   edges; CS_B high resets the pointer to bit 7; the GPIO byte latches on the CS_B rising edge.
// - Mode 0: SCLK idles low, MOSI changes while SCLK is low, MISO is sampled at the rising edge.
// PARAMETERS
// - CLK_DIV   2  CLK cycles per SCLK half-period (>=1)
// - CS_SETUP  2  extra CLK cycles of SCLK low between CS_B fall and the first SCLK rise (>=0)
// - CS_HOLD   2  CLK cycles from the last SCLK fall to the CS_B rise (>=1)
// - CS_IDLE   4  minimum CLK cycles CS_B stays high between transactions (>=1)
// PORTS
// - CLK      in   1  system clock; all logic on posedge
// - RST_N    in   1  asynchronous active-low reset
// - START    in   1  request a transaction; sampled only in IDLE
// - TX_DATA  in   8  GPIO byte; captured in the cycle START is accepted
// - BUSY     out  1  high from the cycle after acceptance through the end of GAP
// - DONE     out  1  1-cycle pulse when RX_DATA is updated
// - RX_DATA  out  8  last received ToT byte; held until the next DONE
// - SCLK     out  1  SPI clock to the CPLD
// - MOSI     out  1  SPI data to the CPLD
// - CS_B     out  1  SPI chip select, active low
// - MISO     in   1  SPI data from the CPLD
// BEHAVIOUR
// - Reset (async, RST_N=0) forces: CS_B=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, state=IDLE, counters=0.
// - Reset mid-transfer: CS_B rises immediately, which latches a partial byte in the slave (accepted).
//   No DONE is produced. The first transaction after reset is clean.
// - MISO passes through one input register (miso_q) every CLK. Sampling uses miso_q.
// - Every SPI output (SCLK, MOSI, CS_B) is registered; there is no combinational path to the pins.
// - States:
//   IDLE:  START=1 -> tx_sr<=TX_DATA, CS_B<=0, MOSI<=TX_DATA[7], bit_cnt<=0, div_cnt<=0, BUSY<=1 -> LOW.
//   LOW:   SCLK=0. Lasts CS_SETUP+CLK_DIV cycles for bit 7 and CLK_DIV cycles for bits 6..0.
//          At the end: SCLK<=1, rx_sr<={rx_sr[6:0],miso_q} -> HIGH.
//   HIGH:  SCLK=1 for CLK_DIV cycles. At the end: SCLK<=0.
//          If bit_cnt==7 -> TRAIL; else MOSI<=tx_sr[6-bit_cnt], bit_cnt++ -> LOW.
//   TRAIL: CS_HOLD cycles. At the end: CS_B<=1, MOSI<=0, RX_DATA<=rx_sr, DONE<=1 -> GAP.
//   GAP:   CS_IDLE cycles with CS_B high. At the end: BUSY<=0 -> IDLE.
// - CS_B low duration: exactly CS_SETUP + 16*CLK_DIV + CS_HOLD CLK cycles.
// - Pulse count: exactly 8 SCLK rising edges per transaction, never more and never fewer.
// - START while BUSY (including the DONE and GAP cycles) is ignored; there is no queueing.
// - START held high: a new transaction starts in the first IDLE cycle.
// - Counter widths: div_cnt is $clog2(CS_SETUP+CLK_DIV+CS_HOLD+CS_IDLE+1) bits; bit_cnt is 3 bits
//   and does not wrap (it exits at 7).
// - The ToT counter in the CPLD may change while it is being shifted out, so RX_DATA is not atomic.
//   Software reads ToT only after INJ has settled; the block does not compensate.
// STRUCTURE
// - Package afe_spi_pkg holds the state enum {IDLE,LOW,HIGH,TRAIL,GAP} and AFE_SPI_WIDTH=8.
// - One sub-module: afe_spi_tick, a reloadable down-counter that emits a 1-cycle tick after N cycles.
//   It is shared by all timed states. Everything else stays in afe_spi_master.
// TESTING
// - Bench includes a behavioural model of the CPLD slave: MISO=tot[ptr]; ptr resets on CS_B high
//   and decrements on SCLK rise; gpio latches on CS_B rise.
// - Tests 1-4 use the default parameters; test 5 overrides CLK_DIV.
// 1. TX=0xA5, tot=0x3C -> MOSI bits 1,0,1,0,0,1,0,1 at the rises; model gpio=0xA5; RX_DATA=0x3C;
//    DONE 1 cycle; CS_B low 36 cycles; 8 SCLK rises.
// 2. START held high, TX=0xFF then 0x00 -> two transactions; CS_B high >=4 cycles between them;
//    model gpio ends at 0x00.
// 3. START pulsed during bit 4 of a transfer -> ignored; exactly one DONE; no extra SCLK edges.
// 4. RST_N low after the 3rd SCLK rise -> CS_B=1 and SCLK=0 asynchronously; no DONE; RX_DATA=0;
//    next transaction TX=0x81 / tot=0x7E returns 0x7E.
// 5. CLK_DIV=1, tot=0x00 then 0xFF -> RX_DATA 0x00 then 0xFF; SCLK high/low each 1 cycle; 8 rises.

Source files
------------

// File: rtl/afe_spi_pkg.sv
// Shared constants for the AFE CPLD SPI master: byte width and FSM state codes.
package afe_spi_pkg;

  localparam int AFE_SPI_WIDTH = 8;

  // FSM state codes
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOW   = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Index of the last bit of a transfer (bit_cnt exits here instead of wrapping)
  localparam logic [2:0] LAST_BIT = 3'(AFE_SPI_WIDTH - 1);

endpackage

// File: rtl/afe_spi_tick.sv
// Reloadable down-counter: after a load of N, tick is high in the Nth cycle
// following the load. Reloading in the tick cycle gives back-to-back periods.
module afe_spi_tick #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  // Count down from the loaded value and park at zero when not reloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == W'(1));

endmodule

// File: rtl/afe_spi_master.sv
// SPI master (mode 0, MSB first) for the AFE CPLD slave port. One transaction
// is exactly 8 SCLK pulses inside one CS_B low window: the GPIO byte goes out on
// MOSI and the ToT byte comes back on MISO. All pin outputs are registered.
module afe_spi_master
  import afe_spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,  // clk cycles per SCLK half-period
  parameter int CS_SETUP = 2,  // extra SCLK-low cycles before the first rise
  parameter int CS_HOLD  = 2,  // last SCLK fall to CS_B rise
  parameter int CS_IDLE  = 4   // minimum CS_B high time between transfers
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AFE_SPI_WIDTH-1:0] tx_data,
  output logic                     busy,
  output logic                     done,
  output logic [AFE_SPI_WIDTH-1:0] rx_data,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     cs_b,
  input  logic                     miso
);

  localparam int CW = $clog2(CS_SETUP + CLK_DIV + CS_HOLD + CS_IDLE + 1);

  localparam logic [CW-1:0] LD_FIRST = CW'(CS_SETUP + CLK_DIV);
  localparam logic [CW-1:0] LD_HALF  = CW'(CLK_DIV);
  localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD);
  localparam logic [CW-1:0] LD_GAP   = CW'(CS_IDLE);

  logic [2:0]               state;
  logic [2:0]               bit_cnt;
  logic [AFE_SPI_WIDTH-1:0] tx_sr;
  logic [AFE_SPI_WIDTH-1:0] rx_sr;
  logic                     miso_q;

  logic                     tick;
  logic                     tick_load;
  logic [CW-1:0]            tick_val;

  // One timer serves every timed state; it is reloaded on each state entry
  afe_spi_tick #(.W(CW)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tick_load),
    .load_val (tick_val),
    .tick     (tick)
  );

  // MISO is asynchronous to clk; sample only the registered copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miso_q <= 1'b0;
    else        miso_q <= miso;
  end

  // Select the duration of the state being entered on this cycle's transition
  always_comb begin
    tick_load = 1'b0;
    tick_val  = '0;
    case (state)
      ST_IDLE: if (start) begin
        tick_load = 1'b1;
        tick_val  = LD_FIRST;
      end
      ST_LOW: if (tick) begin
        tick_load = 1'b1;
        tick_val  = LD_HALF;
      end
      ST_HIGH: if (tick) begin
        tick_load = 1'b1;
        tick_val  = (bit_cnt == LAST_BIT) ? LD_HOLD : LD_HALF;
      end
      ST_TRAIL: if (tick) begin
        tick_load = 1'b1;
        tick_val  = LD_GAP;
      end
      default: ;
    endcase
  end

  // Transfer sequencing: IDLE -> (LOW -> HIGH) x8 -> TRAIL -> GAP -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_b    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sr   <= tx_data;
            mosi    <= tx_data[AFE_SPI_WIDTH-1];
            cs_b    <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tick) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[AFE_SPI_WIDTH-2:0], miso_q};
            state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state <= ST_TRAIL;
            end else begin
              // Rotate so the next bit to send always sits at [6]; MOSI
              // changes on the SCLK fall, half a period before the next rise
              mosi    <= tx_sr[AFE_SPI_WIDTH-2];
              tx_sr   <= {tx_sr[AFE_SPI_WIDTH-2:0], tx_sr[AFE_SPI_WIDTH-1]};
              bit_cnt <= bit_cnt + 3'd1;
              state   <= ST_LOW;
            end
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            cs_b    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= rx_sr;
            done    <= 1'b1;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
